// File: rtl/cus42_vram_arbiter_if.sv
// Signal bundle for cus42_vram_arbiter: layer cells, CPU handshake, tile RAM port and tile words.
// The vblank input exists only when CUS42_VBLANK_CPU_EN is defined.
interface cus42_vram_arbiter_if;
   logic        hsync;
   logic [10:0] la_cell;
   logic [10:0] lb_cell;
   logic        cpu_req;
   logic        cpu_we;
   logic [12:0] cpu_a;
   logic [7:0]  cpu_di;
   logic [7:0]  cpu_do;
   logic        cpu_ack;
   logic [12:0] ra;
   logic [7:0]  rd_o;
   logic [7:0]  rd_i;
   logic        rwe;
   logic        roe;
   logic [15:0] la_tile;
   logic        la_valid;
   logic [15:0] lb_tile;
   logic        lb_valid;
`ifdef CUS42_VBLANK_CPU_EN
   logic        vblank;
`endif

   modport slave (
`ifdef CUS42_VBLANK_CPU_EN
      input  vblank,
`endif
      input  hsync, la_cell, lb_cell, cpu_req, cpu_we, cpu_a, cpu_di, rd_i,
      output cpu_do, cpu_ack, ra, rd_o, rwe, roe, la_tile, la_valid, lb_tile, lb_valid
   );

   modport master (
`ifdef CUS42_VBLANK_CPU_EN
      output vblank,
`endif
      output hsync, la_cell, lb_cell, cpu_req, cpu_we, cpu_a, cpu_di, rd_i,
      input  cpu_do, cpu_ack, ra, rd_o, rwe, roe, la_tile, la_valid, lb_tile, lb_valid
   );
endinterface

// File: rtl/cus42_vram_arbiter.sv
// Tilemap RAM slot arbiter: 8-phase cell with layer A/B byte fetches and a CPU window.
// Optional CUS42_VBLANK_CPU_EN turns every phase into a CPU slot while vblank is high.
module cus42_vram_arbiter #(
   parameter logic        HSYNC_ACTIVE  = 1'b1,
   parameter int unsigned CPU_LAST_SLOT = 6
) (
   input logic                 i_clk_6m,
   input logic                 i_rst_n,
   cus42_vram_arbiter_if.slave io_bus
);

   localparam logic [2:0] LastSlot = 3'(CPU_LAST_SLOT);

   typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

   state_e      r_state, w_state_nxt;
   logic [2:0]  r_phase, w_phase_nxt;
   logic        r_hsync, w_hs_edge;
   logic        r_granted, w_granted_nxt, w_grant, w_win, w_vblank;
   logic        r_cpu_rd, w_cpu_rd_nxt;
   logic [12:0] r_ra, w_ra_nxt;
   logic [7:0]  r_rd_o, w_rd_o_nxt;
   logic        r_roe, w_roe_nxt, r_rwe, w_rwe_nxt;
   logic        r_fetch, w_fetch_nxt, r_cap_ok, w_cap;
   logic        r_half, w_half_nxt;
   logic [15:0] r_la_tile, w_la_tile_nxt, r_lb_tile, w_lb_tile_nxt;
   logic        r_la_valid, w_la_valid_nxt, r_lb_valid, w_lb_valid_nxt;

`ifdef CUS42_VBLANK_CPU_EN
   assign w_vblank = io_bus.vblank;
`else
   assign w_vblank = 1'b0;
`endif

   assign w_hs_edge   = (io_bus.hsync == HSYNC_ACTIVE) && (r_hsync != HSYNC_ACTIVE);
   assign w_phase_nxt = w_hs_edge ? 3'd0 : r_phase + 3'd1;
   assign w_win       = w_vblank || (w_phase_nxt[2] && (w_phase_nxt <= LastSlot));
   // The grant flag belongs to the current cell; a next phase of 0 starts a fresh cell.
   assign w_grant     = (r_state == StIdle) && io_bus.cpu_req && w_win &&
                        (!r_granted || (w_phase_nxt == 3'd0));
   assign w_granted_nxt = w_grant ? 1'b1 : ((w_phase_nxt == 3'd0) ? 1'b0 : r_granted);

   always_comb begin
      w_state_nxt  = r_state;
      w_ra_nxt     = r_ra;
      w_rd_o_nxt   = r_rd_o;
      w_roe_nxt    = 1'b0;
      w_rwe_nxt    = 1'b0;
      w_fetch_nxt  = 1'b0;
      w_cpu_rd_nxt = r_cpu_rd;
      unique case (r_state)
         StIdle:   if (w_grant) w_state_nxt = StAccess;
         StAccess: w_state_nxt = StDone;
         StDone:   w_state_nxt = StIdle;
         default:  w_state_nxt = StIdle;
      endcase
      if (w_grant) begin
         w_ra_nxt     = io_bus.cpu_a;
         w_cpu_rd_nxt = !io_bus.cpu_we;
         if (io_bus.cpu_we) begin
            w_rwe_nxt  = 1'b1;
            w_rd_o_nxt = io_bus.cpu_di;
         end else begin
            w_roe_nxt = 1'b1;
         end
      end else if (!w_vblank && !w_phase_nxt[2]) begin
         w_fetch_nxt = 1'b1;
         w_roe_nxt   = 1'b1;
         w_ra_nxt    = {w_phase_nxt[1], w_phase_nxt[1] ? io_bus.lb_cell : io_bus.la_cell,
                        w_phase_nxt[0]};
      end
   end

   // Data on rd_i belongs to last cycle's address; drop it if that fetch is being cut short.
   assign w_cap = r_cap_ok && !w_hs_edge;

   always_comb begin
      w_la_tile_nxt  = r_la_tile;
      w_lb_tile_nxt  = r_lb_tile;
      w_la_valid_nxt = 1'b0;
      w_lb_valid_nxt = 1'b0;
      w_half_nxt     = 1'b0;
      case (r_phase)
         3'd1: if (w_cap) begin
            w_la_tile_nxt[7:0] = io_bus.rd_i;
            w_half_nxt         = 1'b1;
         end
         3'd2: if (w_cap && r_half) begin
            w_la_tile_nxt[15:8] = io_bus.rd_i;
            w_la_valid_nxt      = 1'b1;
         end
         3'd3: if (w_cap) begin
            w_lb_tile_nxt[7:0] = io_bus.rd_i;
            w_half_nxt         = 1'b1;
         end
         3'd4: if (w_cap && r_half) begin
            w_lb_tile_nxt[15:8] = io_bus.rd_i;
            w_lb_valid_nxt      = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk_6m or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= StIdle;
         r_phase    <= 3'd0;
         r_hsync    <= ~HSYNC_ACTIVE;
         r_granted  <= 1'b0;
         r_cpu_rd   <= 1'b0;
         r_ra       <= 13'd0;
         r_rd_o     <= 8'd0;
         r_roe      <= 1'b0;
         r_rwe      <= 1'b0;
         r_fetch    <= 1'b0;
         r_cap_ok   <= 1'b0;
         r_half     <= 1'b0;
         r_la_tile  <= 16'd0;
         r_lb_tile  <= 16'd0;
         r_la_valid <= 1'b0;
         r_lb_valid <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_phase    <= w_phase_nxt;
         r_hsync    <= io_bus.hsync;
         r_granted  <= w_granted_nxt;
         r_cpu_rd   <= w_cpu_rd_nxt;
         r_ra       <= w_ra_nxt;
         r_rd_o     <= w_rd_o_nxt;
         r_roe      <= w_roe_nxt;
         r_rwe      <= w_rwe_nxt;
         r_fetch    <= w_fetch_nxt;
         r_cap_ok   <= r_fetch;
         r_half     <= w_half_nxt;
         r_la_tile  <= w_la_tile_nxt;
         r_lb_tile  <= w_lb_tile_nxt;
         r_la_valid <= w_la_valid_nxt;
         r_lb_valid <= w_lb_valid_nxt;
      end
   end

   // Read data arrives on rd_i in the DONE cycle, so it is forwarded alongside the ACK.
   assign io_bus.cpu_do   = ((r_state == StDone) && r_cpu_rd) ? io_bus.rd_i : 8'h00;
   assign io_bus.cpu_ack  = (r_state == StDone);
   assign io_bus.ra       = r_ra;
   assign io_bus.rd_o     = r_rd_o;
   assign io_bus.roe      = r_roe;
   assign io_bus.rwe      = r_rwe;
   assign io_bus.la_tile  = r_la_tile;
   assign io_bus.la_valid = r_la_valid;
   assign io_bus.lb_tile  = r_lb_tile;
   assign io_bus.lb_valid = r_lb_valid;

endmodule

// File: tb/tb_cus42_vram_arbiter.sv
// Scoreboard bench for cus42_vram_arbiter: CPU ACKs are checked against queued expectations,
// layer tile pulses against fixed RAM contents and a phase reference.
module tb_cus42_vram_arbiter;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;
   int   la_cnt   = 0;
   int   lb_cnt   = 0;

   typedef struct {
      int         cyc;
      logic       rd;
      logic [7:0] data;
   } exp_t;

   exp_t       cpu_q[$];
   exp_t       mon_e;
   logic [7:0] mem [0:8191];
   logic       ram_init = 1'b0;
   logic [2:0] tb_ph;
   logic       tb_hs;

   cus42_vram_arbiter_if bus_if ();

   cus42_vram_arbiter #(
      .HSYNC_ACTIVE (1'b1),
      .CPU_LAST_SLOT(6)
   ) dut (
      .i_clk_6m(clk),
      .i_rst_n (rst_n),
      .io_bus  (bus_if.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous RAM: data for the address seen at a rising edge appears after that edge.
   always @(posedge clk) begin
      if (!ram_init) begin
         for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
         mem[13'h0246] <= 8'h11;
         mem[13'h0247] <= 8'h22;
         mem[13'h108A] <= 8'h33;
         mem[13'h108B] <= 8'h44;
         mem[13'h0010] <= 8'hC3;
         ram_init      <= 1'b1;
      end else begin
         bus_if.rd_i <= mem[bus_if.ra];
         if (bus_if.rwe) mem[bus_if.ra] <= bus_if.rd_o;
      end
   end

   // Reference phase: +1 per clock, restart on rising HSYNC.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tb_ph <= 3'd0;
         tb_hs <= 1'b0;
      end else begin
         tb_hs <= bus_if.hsync;
         tb_ph <= (bus_if.hsync && !tb_hs) ? 3'd0 : tb_ph + 3'd1;
      end
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   task automatic note_fail(input string name);
      n_checks++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (bus_if.cpu_ack) begin
            if (cpu_q.size() == 0) begin
               n_checks++;
               $display("FAIL cpu_ack_unexpected: got ack at cycle %0d expected none", cyc);
            end else begin
               mon_e = cpu_q.pop_front();
               chk("cpu_ack_cycle", cyc, mon_e.cyc);
               if (mon_e.rd) chk("cpu_do", {24'd0, bus_if.cpu_do}, {24'd0, mon_e.data});
            end
         end
         if (bus_if.la_valid) begin
            la_cnt++;
            chk("la_valid_phase", {29'd0, tb_ph}, 32'd3);
            chk("la_tile", {16'd0, bus_if.la_tile}, 32'h2211);
         end
         if (bus_if.lb_valid) begin
            lb_cnt++;
            chk("lb_valid_phase", {29'd0, tb_ph}, 32'd5);
            chk("lb_tile", {16'd0, bus_if.lb_tile}, 32'h4433);
         end
      end
   end

   task automatic wait_phase(input logic [2:0] p);
      int n = 0;
      @(negedge clk);
      while (tb_ph != p && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (tb_ph != p) note_fail("wait_phase");
   endtask

   task automatic wait_ack();
      int n = 0;
      @(negedge clk);
      while (!bus_if.cpu_ack && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus_if.cpu_ack) note_fail("wait_ack");
   endtask

   task automatic cpu_issue(input logic [2:0] ph, input logic we, input logic [12:0] a,
                            input logic [7:0] di, input logic [7:0] exp_d, input int lat,
                            input int n_acc);
      wait_phase(ph);
      bus_if.cpu_we  = we;
      bus_if.cpu_a   = a;
      bus_if.cpu_di  = di;
      bus_if.cpu_req = 1'b1;
      for (int k = 0; k < n_acc; k++) cpu_q.push_back('{cyc + lat + 8 * k, !we, exp_d});
      for (int k = 0; k < n_acc; k++) wait_ack();
      bus_if.cpu_req = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   logic [12:0] exp_ra [4];
   int          la_before, lb_before;

   initial begin
      exp_ra = '{13'h0246, 13'h0247, 13'h108A, 13'h108B};
      rst_n           = 1'b0;
      bus_if.hsync    = 1'b0;
      bus_if.la_cell  = 11'h123;
      bus_if.lb_cell  = 11'h045;
      bus_if.cpu_req  = 1'b0;
      bus_if.cpu_we   = 1'b0;
      bus_if.cpu_a    = 13'd0;
      bus_if.cpu_di   = 8'd0;
`ifdef CUS42_VBLANK_CPU_EN
      bus_if.vblank   = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_ra", {19'd0, bus_if.ra}, 32'd0);
      chk("rst_rd_o", {24'd0, bus_if.rd_o}, 32'd0);
      chk("rst_rwe", {31'd0, bus_if.rwe}, 32'd0);
      chk("rst_roe", {31'd0, bus_if.roe}, 32'd0);
      chk("rst_cpu_do", {24'd0, bus_if.cpu_do}, 32'd0);
      chk("rst_cpu_ack", {31'd0, bus_if.cpu_ack}, 32'd0);
      chk("rst_la_tile", {16'd0, bus_if.la_tile}, 32'd0);
      chk("rst_lb_tile", {16'd0, bus_if.lb_tile}, 32'd0);
      chk("rst_la_valid", {31'd0, bus_if.la_valid}, 32'd0);
      chk("rst_lb_valid", {31'd0, bus_if.lb_valid}, 32'd0);
      rst_n = 1'b1;

      // Free-run fetch sequence of a full cell.
      wait_phase(3'd7);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("ra_fetch", {19'd0, bus_if.ra}, {19'd0, exp_ra[k]});
         chk("roe_fetch", {31'd0, bus_if.roe}, 32'd1);
      end

      // CPU write requested at phase 2: access in phase 4, ACK in phase 5.
      wait_phase(3'd2);
      bus_if.cpu_we  = 1'b1;
      bus_if.cpu_a   = 13'h1ABC;
      bus_if.cpu_di  = 8'h5A;
      bus_if.cpu_req = 1'b1;
      cpu_q.push_back('{cyc + 3, 1'b0, 8'h00});
      wait_phase(3'd4);
      chk("wr_rwe", {31'd0, bus_if.rwe}, 32'd1);
      chk("wr_ra", {19'd0, bus_if.ra}, 32'h1ABC);
      chk("wr_rd_o", {24'd0, bus_if.rd_o}, 32'h5A);
      chk("wr_roe", {31'd0, bus_if.roe}, 32'd0);
      wait_ack();
      bus_if.cpu_req = 1'b0;
      @(negedge clk);
      chk("wr_mem", {24'd0, mem[13'h1ABC]}, 32'h5A);

      // Read requested at phase 7 waits for the next window: 6-cycle latency.
      cpu_issue(3'd7, 1'b0, 13'h0010, 8'h00, 8'hC3, 6, 1);

      // REQ held through ACK: one access per cell, second ACK 8 cycles after the first.
      cpu_issue(3'd3, 1'b0, 13'h1ABC, 8'h00, 8'h5A, 2, 2);
      repeat (16) @(negedge clk);

      // HSYNC restart during a read ACCESS.
      wait_phase(3'd3);
      bus_if.cpu_we  = 1'b0;
      bus_if.cpu_a   = 13'h0010;
      bus_if.cpu_req = 1'b1;
      cpu_q.push_back('{cyc + 2, 1'b1, 8'hC3});
      @(negedge clk);
      la_before    = la_cnt;
      lb_before    = lb_cnt;
      bus_if.hsync = 1'b1;
      wait_ack();
      bus_if.cpu_req = 1'b0;
      chk("hs_ra_phase0", {19'd0, bus_if.ra}, 32'h0246);
      chk("hs_roe_phase0", {31'd0, bus_if.roe}, 32'd1);
      chk("hs_no_lb_valid", {31'd0, bus_if.lb_valid}, 32'd0);
      @(negedge clk);
      bus_if.hsync = 1'b0;
      wait_phase(3'd6);
      chk("hs_la_count", la_cnt, la_before + 1);
      chk("hs_lb_count", lb_cnt, lb_before + 1);

      // Reset in the middle of a write: strobes drop at once, no ACK, RAM untouched.
      wait_phase(3'd3);
      bus_if.cpu_we  = 1'b1;
      bus_if.cpu_a   = 13'h0100;
      bus_if.cpu_di  = 8'h77;
      bus_if.cpu_req = 1'b1;
      @(negedge clk);
      chk("rw_rwe_before", {31'd0, bus_if.rwe}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rw_rwe_async", {31'd0, bus_if.rwe}, 32'd0);
      chk("rw_ack_async", {31'd0, bus_if.cpu_ack}, 32'd0);
      chk("rw_ra_async", {19'd0, bus_if.ra}, 32'd0);
      bus_if.cpu_req = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rw_mem_untouched", {24'd0, mem[13'h0100]}, 32'd0);
      repeat (12) @(negedge clk);

`ifdef CUS42_VBLANK_CPU_EN
      // VBLANK: any phase is a CPU slot and layer fetches stop.
      wait_phase(3'd7);
      bus_if.vblank = 1'b1;
      la_before     = la_cnt;
      lb_before     = lb_cnt;
      wait_phase(3'd0);
      bus_if.cpu_we  = 1'b0;
      bus_if.cpu_a   = 13'h0010;
      bus_if.cpu_req = 1'b1;
      cpu_q.push_back('{cyc + 2, 1'b1, 8'hC3});
      @(negedge clk);
      chk("vb_ra_phase1", {19'd0, bus_if.ra}, 32'h0010);
      wait_ack();
      bus_if.cpu_req = 1'b0;
      wait_phase(3'd7);
      chk("vb_la_count", la_cnt, la_before);
      chk("vb_lb_count", lb_cnt, lb_before);
      bus_if.vblank = 1'b0;
`endif

      repeat (20) @(negedge clk);
      chk("cpu_q_empty", cpu_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/cus42_vram_arbiter.md
Name: cus42_vram_arbiter

Overview:
- Time-slot controller for the shared tilemap RAM behind the CUS42 tilemap address generator.
- Divides each 8-pixel character cell (8 CLK_6M cycles) into fixed slots: two tile-byte fetches for layer A, two for layer B, and a CPU window.
- Drives RA/RD/ROE/RWE, assembles 16-bit tile words per layer, and gives the CPU a REQ/ACK handshake with bounded wait.

Parameters:
- HSYNC_ACTIVE, 1: HSYNC level treated as asserted; the phase restarts on its asserting edge.
- CPU_LAST_SLOT, 6: last phase in which a CPU access may be granted. The window starts at phase 4. Legal values are 4..6.

Ports:
- CLK_6M  in  1  pixel clock; all logic on posedge
- RST_N  in  1  reset; asynchronous, active-low
- HSYNC  in  1  horizontal sync, synchronous to CLK_6M
- LA_CELL  in  11  layer A tile cell index from the address generator
- LB_CELL  in  11  layer B tile cell index
- CPU_REQ  in  1  CPU access request, level
- CPU_WE  in  1  1 = write, 0 = read
- CPU_A  in  13  CPU RAM address
- CPU_DI  in  8  CPU write data
- CPU_DO  out  8  CPU read data, valid with CPU_ACK
- CPU_ACK  out  1  one-cycle completion pulse
- RA  out  13  RAM address
- RD_O  out  8  RAM write data
- RD_I  in  8  RAM read data, valid the cycle after the address
- RWE  out  1  RAM write enable, active-high
- ROE  out  1  RAM output enable, active-high
- LA_TILE  out  16  layer A tile word {byte1, byte0}
- LA_VALID  out  1  one-cycle pulse: LA_TILE updated
- LB_TILE  out  16  layer B tile word
- LB_VALID  out  1  one-cycle pulse: LB_TILE updated

Behaviour:
- Reset values: phase=0, RA=0, RD_O=0, RWE=0, ROE=0, CPU_DO=0, CPU_ACK=0, LA/LB_TILE=0, LA/LB_VALID=0, no CPU access pending.
- Phase counter: 3 bits, +1 per clock, wraps 7->0.
  - HSYNC is registered once. On its asserting edge (registered value inactive, input active) the phase is 0 in the next cycle.
- Bus outputs are registered. "During phase k" means the value present while the phase register equals k.
  - Phase 0: RA={0,LA_CELL,0}, ROE=1.
  - Phase 1: RA={0,LA_CELL,1}, ROE=1.
  - Phase 2: RA={1,LB_CELL,0}, ROE=1.
  - Phase 3: RA={1,LB_CELL,1}, ROE=1.
  - Phases 4..7: CPU window, otherwise ROE=0, RWE=0, RA held.
- Capture pipeline: each cycle, RD_I is captured for the address presented in the previous cycle.
  - End of phase 1: LA_TILE[7:0]. End of phase 2: LA_TILE[15:8]. LA_VALID=1 during phase 3.
  - End of phase 3: LB_TILE[7:0]. End of phase 4: LB_TILE[15:8]. LB_VALID=1 during phase 5.
- CPU FSM states: IDLE, ACCESS, DONE.
  - IDLE->ACCESS: CPU_REQ=1 and the next phase is in 4..CPU_LAST_SLOT and no grant yet this cell.
  - In ACCESS, RA=CPU_A for one cycle.
    - Read: ROE=1.
    - Write: RWE=1, RD_O=CPU_DI, ROE=0.
  - ACCESS->DONE: CPU_ACK=1 for one cycle. For a read, CPU_DO=RD_I captured that cycle.
  - DONE->IDLE.
- Grant limits: at most one grant per cell; the grant flag clears at phase 0.
  - The CPU must hold A/WE/DI stable until ACK and deassert REQ on the ACK cycle, or a second access starts in the next cell.
  - Worst-case REQ-to-ACK latency is 7 cycles.
- HSYNC restart during ACCESS or DONE: the access still completes (write pulse, capture, ACK). The layer captures follow the new phase.
- A capture scheduled against an interrupted phase is discarded; no VALID pulse for a partial word.
- RST_N low at any time forces the reset values immediately. An in-flight CPU access is abandoned with no ACK.

Optional Feature:
- Macro CUS42_VBLANK_CPU_EN. Defined: adds input VBLANK (1 bit).
  - While VBLANK=1, all phases 0..7 are CPU slots, still one grant per cell.
  - Layer fetches are suppressed: ROE only for CPU reads, no LA/LB_VALID, tiles held.
- Undefined: the port is absent and the slot map is fixed as above.

Test Plan:
- Reset then free run, LA_CELL=11'h123, LB_CELL=11'h045 -> RA sequence 0x0246, 0x0247, 0x108A, 0x108B; RAM data 0x11, 0x22 gives LA_TILE=0x2211 with LA_VALID in phase 3.
- CPU write A=0x1ABC, DI=0x5A, REQ at phase 2 -> RWE=1 with RA=0x1ABC during phase 4; CPU_ACK in phase 5; RAM holds 0x5A.
- CPU read A=0x0010 (RAM=0xC3), REQ at phase 7 -> grant phase 4 of the next cell, CPU_DO=0xC3 with ACK in phase 5, latency 6 cycles.
- REQ held through ACK -> exactly one access per cell, second ACK exactly 8 cycles later.
- HSYNC edge during a CPU read ACCESS -> ACK still issued with correct data; phase 0 follows; no spurious LB_VALID.
- RST_N pulsed low mid-write -> RWE and CPU_ACK fall asynchronously; with CUS42_VBLANK_CPU_EN, VBLANK=1 and REQ at phase 0 -> grant at phase 1, no LA_VALID.
